// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared constants, types and index helpers for the life generation sequencer
// Purpose: board geometry, colour codes, sequencer state type and padded-board index mapping.
// Ports: none (package).
package life_pkg;

    localparam int GRID_W  = 10;
    localparam int VIS_W   = 8;
    localparam int CELLS   = 64;
    localparam int BOARD_W = GRID_W * GRID_W;

    localparam logic [7:0] COLOR_ALIVE = 8'h4F;
    localparam logic [7:0] COLOR_DEAD  = 8'h11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWEEP  = 2'd1,
        COMMIT = 2'd2
    } seq_state_t;

    // Visible cell (r,c) = idx[5:3], idx[2:0] sits one row and one column in from the border.
    function automatic logic [6:0] pad_index(input logic [5:0] idx);
        return 7'd11 + 7'd10 * {4'd0, idx[5:3]} + {4'd0, idx[2:0]};
    endfunction

    // Expand a 64-bit visible board into the zero-bordered 10x10 vector.
    function automatic logic [BOARD_W-1:0] pad_board(input logic [CELLS-1:0] cells);
        logic [BOARD_W-1:0] b;
        b = '0;
        for (int i = 0; i < CELLS; i++) begin
            b[pad_index(6'(i))] = cells[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/life_gen_timer.sv
// rtl/life_gen_timer.sv - idle-period counter that paces free-running generations
// Purpose: counts enabled cycles and pulses expire_o on the cycle the count reaches GEN_PERIOD-1.
// Ports: clk, rst (async active-high), en_i (count enable), clear_i (synchronous clear, wins over
//        en_i), expire_o (combinational pulse while enabled at the terminal count).
module life_gen_timer #(
    parameter int GEN_PERIOD = 12_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clear_i,
    output logic expire_o
);

    localparam int W = (GEN_PERIOD > 2) ? $clog2(GEN_PERIOD) : 1;
    localparam logic [W-1:0] LAST = W'(GEN_PERIOD - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/life_generation_sequencer.sv
// rtl/life_generation_sequencer.sv - sweeps an 8x8 Game-of-Life board through an external cell calculator
// Purpose: per generation, visits all 64 cells, streams each cell colour to the LED driver, collects
//          the next state in a shadow board and commits it in one cycle. Handles seeding, run/pause,
//          single-step and generation counting.
// Ports: clk, rst (async active-high); run, step, seed_valid/seed_data/seed_ready (control and seeding);
//        calc_pixel, calc_load_sreg, calc_current_state, calc_next_state, calc_pixel_val (calculator);
//        pix_valid, pix_ready, pix_idx, pix_color (LED stream); frame_done, gen_count (status).
module life_generation_sequencer
    import life_pkg::*;
#(
    parameter int GEN_PERIOD = 12_000_000,
    parameter int GEN_CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  step,
    input  logic                  seed_valid,
    input  logic [63:0]           seed_data,
    output logic                  seed_ready,
    output logic [5:0]            calc_pixel,
    output logic                  calc_load_sreg,
    output logic [99:0]           calc_current_state,
    input  logic [99:0]           calc_next_state,
    input  logic [7:0]            calc_pixel_val,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [5:0]            pix_idx,
    output logic [7:0]            pix_color,
    output logic                  frame_done,
    output logic [GEN_CNT_W-1:0]  gen_count
);

    localparam logic [BOARD_W-1:0] INTERIOR_MASK = pad_board({CELLS{1'b1}});

    seq_state_t            state_q, state_d;
    logic [5:0]            idx_q, idx_d;
    logic                  settled_q, settled_d;
    logic [BOARD_W-1:0]    board_q, board_d;
    logic [BOARD_W-1:0]    shadow_q, shadow_d;
    logic [GEN_CNT_W-1:0]  gen_q, gen_d;
    logic                  pix_valid_q, pix_valid_d;
    logic [5:0]            pix_idx_q, pix_idx_d;
    logic [7:0]            pix_color_q, pix_color_d;

    logic                  timer_en;
    logic                  timer_clear;
    logic                  timer_expire;
    logic [6:0]            cur_pad;

    assign timer_en = run && (state_q == IDLE);
    assign cur_pad  = pad_index(idx_q);

    life_gen_timer #(
        .GEN_PERIOD (GEN_PERIOD)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .en_i     (timer_en),
        .clear_i  (timer_clear),
        .expire_o (timer_expire)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        settled_d   = settled_q;
        board_d     = board_q;
        shadow_d    = shadow_q;
        gen_d       = gen_q;
        pix_valid_d = pix_valid_q;
        pix_idx_d   = pix_idx_q;
        pix_color_d = pix_color_q;
        timer_clear = 1'b0;

        case (state_q)
            IDLE: begin
                // Seeding wins over a step or timer expiry arriving in the same cycle.
                if (seed_valid) begin
                    board_d     = pad_board(seed_data);
                    timer_clear = 1'b1;
                end else if (step || timer_expire) begin
                    state_d     = SWEEP;
                    idx_d       = '0;
                    settled_d   = 1'b0;
                    shadow_d    = '0;
                    timer_clear = 1'b1;
                end
            end

            SWEEP: begin
                if (pix_valid_q && pix_ready) begin
                    shadow_d[cur_pad] = calc_next_state[cur_pad];
                    pix_valid_d       = 1'b0;
                    settled_d         = 1'b0;
                    if (idx_q == 6'd63) begin
                        state_d = COMMIT;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end else if (settled_q && !pix_valid_q) begin
                    // Calculator output now reflects idx_q; capture it into the stream registers.
                    pix_valid_d = 1'b1;
                    pix_idx_d   = idx_q;
                    pix_color_d = calc_pixel_val;
                end else if (!settled_q) begin
                    // Calculator latches calc_pixel on this edge; its colour is usable next cycle.
                    settled_d = 1'b1;
                end
            end

            COMMIT: begin
                board_d = shadow_q & INTERIOR_MASK;
                gen_d   = gen_q + GEN_CNT_W'(1);
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            settled_q   <= 1'b0;
            board_q     <= '0;
            shadow_q    <= '0;
            gen_q       <= '0;
            pix_valid_q <= 1'b0;
            pix_idx_q   <= '0;
            pix_color_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            settled_q   <= settled_d;
            board_q     <= board_d;
            shadow_q    <= shadow_d;
            gen_q       <= gen_d;
            pix_valid_q <= pix_valid_d;
            pix_idx_q   <= pix_idx_d;
            pix_color_q <= pix_color_d;
        end
    end

    assign seed_ready         = (state_q == IDLE);
    assign calc_pixel         = (state_q == SWEEP) ? idx_q : 6'd0;
    assign calc_load_sreg     = (state_q != SWEEP);
    assign calc_current_state = board_q;
    assign pix_valid          = pix_valid_q;
    assign pix_idx            = pix_idx_q;
    assign pix_color          = pix_color_q;
    assign frame_done         = (state_q == COMMIT);
    assign gen_count          = gen_q;

endmodule

// File: tb/tb_life_generation_sequencer.sv
// tb/tb_life_generation_sequencer.sv - directed self-checking bench with a behavioural cell calculator
module tb_life_generation_sequencer;

    localparam int GP = 20;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         run = 1'b0;
    logic         step = 1'b0;
    logic         seed_valid = 1'b0;
    logic [63:0]  seed_data = '0;
    logic         seed_ready;
    logic [5:0]   calc_pixel;
    logic         calc_load_sreg;
    logic [99:0]  calc_current_state;
    logic [99:0]  calc_next_state;
    logic [7:0]   calc_pixel_val;
    logic         pix_valid;
    logic         pix_ready = 1'b1;
    logic [5:0]   pix_idx;
    logic [7:0]   pix_color;
    logic         frame_done;
    logic [15:0]  gen_count;

    always #5 clk = ~clk;

    life_generation_sequencer #(
        .GEN_PERIOD (GP),
        .GEN_CNT_W  (16)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .run                (run),
        .step               (step),
        .seed_valid         (seed_valid),
        .seed_data          (seed_data),
        .seed_ready         (seed_ready),
        .calc_pixel         (calc_pixel),
        .calc_load_sreg     (calc_load_sreg),
        .calc_current_state (calc_current_state),
        .calc_next_state    (calc_next_state),
        .calc_pixel_val     (calc_pixel_val),
        .pix_valid          (pix_valid),
        .pix_ready          (pix_ready),
        .pix_idx            (pix_idx),
        .pix_color          (pix_color),
        .frame_done         (frame_done),
        .gen_count          (gen_count)
    );

    // Board helpers: cell (r,c) at padded bit 11+10r+c.
    function automatic logic [99:0] tb_pad(input logic [63:0] cells);
        logic [99:0] b;
        b = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                b[11 + 10*r + c] = cells[8*r + c];
        return b;
    endfunction

    function automatic logic [99:0] life_step(input logic [99:0] b);
        logic [99:0] n;
        int cnt;
        n = '0;
        for (int r = 1; r <= 8; r++)
            for (int c = 1; c <= 8; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (!(dr == 0 && dc == 0)) cnt += int'(b[(r+dr)*10 + (c+dc)]);
                n[r*10 + c] = (cnt == 3) || (b[r*10 + c] && cnt == 2);
            end
        return n;
    endfunction

    // Calculator stand-in: registers the pixel index, colour follows one cycle later.
    logic [5:0] calc_pix_q = '0;
    always @(posedge clk) calc_pix_q <= calc_pixel;
    assign calc_next_state = life_step(calc_current_state);
    assign calc_pixel_val  = calc_next_state[11 + 10*int'(calc_pix_q[5:3]) + int'(calc_pix_q[2:0])] ? 8'h4F : 8'h11;

    // Backpressure driver.
    bit bp_mode = 1'b0;
    always @(posedge clk) begin
        #1;
        pix_ready = bp_mode ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Stream monitor, sampled at the falling edge.
    logic [5:0]  bq_idx[$];
    logic [7:0]  bq_col[$];
    int          stall_err = 0;
    int          board_err = 0;
    bit          mon_en = 1'b0;
    bit          prev_stall = 1'b0;
    bit          prev_sweep = 1'b0;
    logic [5:0]  prev_idx;
    logic [7:0]  prev_col;
    logic [99:0] prev_board;

    always @(negedge clk) begin
        if (mon_en) begin
            if (pix_valid && pix_ready) begin
                bq_idx.push_back(pix_idx);
                bq_col.push_back(pix_color);
            end
            if (prev_stall && (!pix_valid || pix_idx != prev_idx || pix_color != prev_col)) stall_err++;
            if (prev_sweep && !calc_load_sreg && calc_current_state != prev_board) board_err++;
        end
        prev_stall = mon_en && pix_valid && !pix_ready;
        prev_idx   = pix_idx;
        prev_col   = pix_color;
        prev_sweep = mon_en && !calc_load_sreg;
        prev_board = calc_current_state;
    end

    task automatic do_seed(input logic [63:0] d);
        @(posedge clk); #1;
        seed_valid = 1'b1;
        seed_data  = d;
        @(posedge clk); #1;
        seed_valid = 1'b0;
    endtask

    task automatic do_step();
        @(posedge clk); #1;
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 128'(ok), 128'(1));
    endtask

    // Runs one stepped generation and checks the streamed beats against an alive mask.
    task automatic step_and_check(input string tag, input logic [63:0] exp_alive);
        logic [63:0] alive;
        int order_err, col_err;
        bq_idx.delete();
        bq_col.delete();
        do_step();
        wait_frame({tag, "_frame"});
        alive = '0;
        order_err = 0;
        col_err = 0;
        foreach (bq_idx[i]) begin
            if (bq_idx[i] != 6'(i)) order_err++;
            if (bq_col[i] == 8'h4F) alive[bq_idx[i]] = 1'b1;
            else if (bq_col[i] != 8'h11) col_err++;
        end
        chk({tag, "_beats"}, 128'(bq_idx.size()), 128'(64));
        chk({tag, "_order"}, 128'(order_err), 128'(0));
        chk({tag, "_colours"}, 128'(col_err), 128'(0));
        chk({tag, "_alive"}, 128'(alive), 128'(exp_alive));
        @(negedge clk);
        chk({tag, "_pulse"}, 128'(frame_done), 128'(0));
        chk({tag, "_board"}, 128'(calc_current_state), 128'(tb_pad(exp_alive)));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ready"}, 128'(seed_ready), 128'(1));
        chk({tag, "_sreg"}, 128'(calc_load_sreg), 128'(1));
        chk({tag, "_pixel"}, 128'(calc_pixel), 128'(0));
        chk({tag, "_valid"}, 128'(pix_valid), 128'(0));
        chk({tag, "_color"}, 128'(pix_color), 128'(0));
        chk({tag, "_frame"}, 128'(frame_done), 128'(0));
        chk({tag, "_gen"}, 128'(gen_count), 128'(0));
        chk({tag, "_board"}, 128'(calc_current_state), 128'(0));
    endtask

    localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;   // (3,2),(3,3),(3,4)
    localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;   // (2,3),(3,3),(4,3)
    localparam logic [63:0] BLOCK   = 64'h0000_0000_0C0C_0000;   // (2,2),(2,3),(3,2),(3,3)
    localparam logic [63:0] GLIDER0 = 64'h0000_0000_0007_0402;   // (0,1),(1,2),(2,0),(2,1),(2,2)
    localparam logic [63:0] GLIDER1 = 64'h0000_0000_0206_0500;   // (1,0),(1,2),(2,1),(2,2),(3,1)

    logic [5:0] ref_idx[$];
    logic [7:0] ref_col[$];

    initial begin
        int diff, n, sweeps;
        bit ok;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("rst0");
        #1 rst = 1'b0;
        mon_en = 1'b1;

        // Blinker: two generations.
        do_seed(BLINK_H);
        @(negedge clk);
        chk("seed_board", 128'(calc_current_state), 128'(tb_pad(BLINK_H)));
        chk("seed_gen", 128'(gen_count), 128'(0));
        step_and_check("blink1", BLINK_V);
        chk("blink1_gen", 128'(gen_count), 128'(1));
        step_and_check("blink2", BLINK_H);
        chk("blink2_gen", 128'(gen_count), 128'(2));

        // Glider with ready=1, then identical run under backpressure.
        do_seed(GLIDER0);
        step_and_check("glider_ref", GLIDER1);
        ref_idx = bq_idx;
        ref_col = bq_col;
        do_seed(GLIDER0);
        stall_err = 0;
        bp_mode = 1'b1;
        step_and_check("glider_bp", GLIDER1);
        bp_mode = 1'b0;
        diff = 0;
        foreach (ref_idx[i]) begin
            if (i >= bq_idx.size()) diff++;
            else if (ref_idx[i] != bq_idx[i] || ref_col[i] != bq_col[i]) diff++;
        end
        chk("bp_seq_match", 128'(diff), 128'(0));
        chk("bp_stall_stable", 128'(stall_err), 128'(0));
        chk("bp_gen", 128'(gen_count), 128'(4));

        // Seed and step during a sweep are ignored.
        do_seed(BLINK_H);
        do_step();
        ok = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (!calc_load_sreg && calc_pixel == 6'd10) begin
                ok = 1'b1;
                break;
            end
        end
        chk("mid_reach_idx10", 128'(ok), 128'(1));
        chk("mid_seed_ready", 128'(seed_ready), 128'(0));
        seed_valid = 1'b1;
        seed_data  = '1;
        step       = 1'b1;
        @(negedge clk);
        @(negedge clk);
        seed_valid = 1'b0;
        step       = 1'b0;
        wait_frame("mid_frame");
        repeat (5) @(negedge clk);
        chk("mid_board", 128'(calc_current_state), 128'(tb_pad(BLINK_V)));
        chk("mid_no_resweep", 128'(calc_load_sreg), 128'(1));
        chk("mid_gen", 128'(gen_count), 128'(5));
        chk("sweep_board_stable", 128'(board_err), 128'(0));

        // Reset, then block still-life over five generations.
        mon_en = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_state("rst1");
        @(posedge clk); #1 rst = 1'b0;
        mon_en = 1'b1;
        do_seed(BLOCK);
        for (int g = 0; g < 5; g++) begin
            step_and_check($sformatf("block%0d", g), BLOCK);
        end
        chk("block_gen", 128'(gen_count), 128'(5));

        // Timer pacing: 20 idle cycles between commit and next sweep.
        run = 1'b1;
        wait_frame("timer_first");
        for (int g = 0; g < 2; g++) begin
            n = 0;
            while (n < 200) begin
                @(negedge clk);
                if (!calc_load_sreg) break;
                n++;
            end
            chk($sformatf("timer_gap%0d", g), 128'(n), 128'(GP));
            wait_frame($sformatf("timer_frame%0d", g));
        end
        run = 1'b0;
        sweeps = 0;
        repeat (100) begin
            @(negedge clk);
            if (!calc_load_sreg) sweeps++;
        end
        chk("timer_paused", 128'(sweeps), 128'(0));
        chk("timer_gen", 128'(gen_count), 128'(8));
        chk("timer_board", 128'(calc_current_state), 128'(tb_pad(BLOCK)));

        // Asynchronous reset in the middle of a sweep.
        do_step();
        ok = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (pix_valid && pix_idx == 6'd30) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rst_reach_idx30", 128'(ok), 128'(1));
        mon_en = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_state("rst_mid");
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_after", 128'(calc_load_sreg), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
